sc_hwa_engine: RTL and testbench

- Parametrised stochastic-computing hardware weighted adder for SC FIR filter banks. Generalises fixed-tree HWA blocks to TAPS inputs with run-time-loadable quantised weights and sign mask.
- Owns its own 2^N-cycle select counter and a start/busy/done handshake.
- Converts binary taps to bitstreams against an external RNG value, selects one signed bit per cycle by inverse-CDF on the weights, and counts the ones into a binary result.

---
 rtl/sc_hwa_engine_if.sv | 27 ++
 rtl/sc_hwa_engine.sv | 136 +++++++++++++
 tb/tb_sc_hwa_engine.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sc_hwa_engine_if.sv
// Handshake and data bundle of the stochastic-computing weighted adder.
// The master side requests an accumulation and supplies the tap data. The slave
// side is the engine, which returns busy, done and the ones count.
interface sc_hwa_engine_if #(
    parameter int N    = 8,
    parameter int TAPS = 20,
    parameter int WW   = N + 1
);
    logic                  start;
    logic [TAPS*(N+1)-1:0] x_flat;
    logic [TAPS*WW-1:0]    w_flat;
    logic [TAPS-1:0]       sign_mask;
    logic [N-1:0]          r_y;
    logic                  busy;
    logic                  done;
    logic [N:0]            result;

    modport master (
        output start, x_flat, w_flat, sign_mask, r_y,
        input  busy, done, result
    );

    modport slave (
        input  start, x_flat, w_flat, sign_mask, r_y,
        output busy, done, result
    );
endinterface

// File: rtl/sc_hwa_engine.sv
// Stochastic-computing hardware weighted adder (HWA) for SC FIR filter banks.
// Each of 2^N cycles picks one tap by inverse-CDF on the quantised weights,
// using the bit-reversed count as the uniform select value. It turns that tap
// into a signed stream bit against the RNG value and counts the ones.
// Build option SC_HWA_SYM_FOLD_EN adds symmetric folding. Weight j then serves
// taps j and TAPS-1-j: tap j in the first half-stream and TAPS-1-j in the second.
module sc_hwa_engine #(
    parameter int N    = 8,
    parameter int TAPS = 20,
    parameter int WW   = N + 1
) (
    input  logic           clock,
    input  logic           reset_n,
    sc_hwa_engine_if.slave io_bus
);
    localparam int XW = N + 1;
    localparam int CW = WW + $clog2(TAPS);
`ifdef SC_HWA_SYM_FOLD_EN
    localparam int NSEL = (TAPS + 1) / 2;
`else
    localparam int NSEL = TAPS;
`endif
    localparam logic [N-1:0] CNT_ONE  = 1;
    localparam logic [N-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

    state_t             r_state;
    logic [N-1:0]       r_cnt;
    logic [TAPS*XW-1:0] r_x;
    logic [NSEL*WW-1:0] r_w;
    logic [TAPS-1:0]    r_sign;
    logic               r_bit;
    logic [N:0]         r_acc;
    logic [N:0]         r_result;
    logic               r_busy;
    logic               r_done;

    logic [N-1:0]       w_s;
    logic [CW-1:0]      w_s_ext;
    logic [XW-1:0]      w_ry;
    logic [CW-1:0]      w_cum;
    logic               w_found;
    logic               w_bit;

    assign w_s_ext = {{(CW-N){1'b0}}, w_s};
    assign w_ry    = {1'b0, io_bus.r_y};

    // Select value: bit-reversed count spreads consecutive cycles over the weight range.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_s = '0;
        for (int b = 0; b < N; b++) begin
            w_s[b] = r_cnt[N-1-b];
        end
    end

    // Inverse-CDF tap selection and signed stream bit; zero when s lands beyond the total weight.
    always_comb begin
        w_cum   = '0;
        w_found = 1'b0;
        w_bit   = 1'b0;
        for (int i = 0; i < NSEL; i++) begin
            w_cum = w_cum + {{(CW-WW){1'b0}}, r_w[i*WW +: WW]};
            if (!w_found && (w_s_ext < w_cum)) begin
                w_found = 1'b1;
`ifdef SC_HWA_SYM_FOLD_EN
                if (r_cnt[N-1]) begin
                    w_bit = (r_x[(TAPS-1-i)*XW +: XW] > w_ry) ^ r_sign[TAPS-1-i];
                end else begin
                    w_bit = (r_x[i*XW +: XW] > w_ry) ^ r_sign[i];
                end
`else
                w_bit = (r_x[i*XW +: XW] > w_ry) ^ r_sign[i];
`endif
            end
        end
    end

    // Control FSM with shadow capture, bit pipeline, accumulator and registered handshake outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_x      <= '0;
            r_w      <= '0;
            r_sign   <= '0;
            r_bit    <= 1'b0;
            r_acc    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (io_bus.start) begin
                        r_x     <= io_bus.x_flat;
                        r_w     <= io_bus.w_flat[NSEL*WW-1:0];
                        r_sign  <= io_bus.sign_mask;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_bit   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_bit <= w_bit;
                    r_acc <= r_acc + {{N{1'b0}}, r_bit};
                    r_cnt <= r_cnt + CNT_ONE;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_acc   <= r_acc + {{N{1'b0}}, r_bit};
                    r_bit   <= 1'b0;
                    r_state <= S_FIN;
                end
                S_FIN: begin
                    r_result <= r_acc;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.busy   = r_busy;
    assign io_bus.done   = r_done;
    assign io_bus.result = r_result;
endmodule

// File: tb/tb_sc_hwa_engine.sv
// Self-checking bench for sc_hwa_engine at N=4, TAPS=4.
// The bench has directed weight and tap vectors, hand-written sequences for
// ignored start and mid-run reset, and random runs checked against a slot-table
// model of the weighted adder. Expectations follow SC_HWA_SYM_FOLD_EN when defined.
module tb_sc_hwa_engine;
    localparam int N    = 4;
    localparam int TAPS = 4;
    localparam int WW   = N + 1;
    localparam int XW   = N + 1;
    localparam int SLEN = 1 << N;
    localparam int XF   = TAPS * XW;
    localparam int WF   = TAPS * WW;
`ifdef SC_HWA_SYM_FOLD_EN
    localparam bit FOLD = 1'b1;
`else
    localparam bit FOLD = 1'b0;
`endif

    typedef struct {
        string           name;
        logic [XF-1:0]   x;
        logic [WF-1:0]   w;
        logic [TAPS-1:0] sg;
        int              exp_plain;
        int              exp_fold;
    } vec_t;

    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_fail;
    int   ry_log[SLEN];
    int   last_result;

    sc_hwa_engine_if #(.N(N), .TAPS(TAPS), .WW(WW)) bus ();

    sc_hwa_engine #(.N(N), .TAPS(TAPS), .WW(WW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .io_bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [19:0] pk(input int a, input int b, input int c, input int d);
        logic [4:0] a5, b5, c5, d5;
        a5 = 5'(a); b5 = 5'(b); c5 = 5'(c); d5 = 5'(d);
        return {d5, c5, b5, a5};
    endfunction

    // Each weight claims a contiguous block of select slots in tap order.
    // Slot s is then looked up for every count, with the bit-reversed count as s.
    function automatic int model(input logic [XF-1:0] x, input logic [WF-1:0] w,
                                 input logic [TAPS-1:0] sg);
        int slot_tap[SLEN];
        int pos, ones, nw, s, j, tap, xv;
        nw = FOLD ? (TAPS + 1) / 2 : TAPS;
        for (int k = 0; k < SLEN; k++) slot_tap[k] = -1;
        pos = 0;
        for (int i = 0; i < nw; i++) begin
            for (int k = 0; k < int'(w[i*WW +: WW]); k++) begin
                if (pos < SLEN) begin
                    slot_tap[pos] = i;
                    pos++;
                end
            end
        end
        ones = 0;
        for (int c = 0; c < SLEN; c++) begin
            s = 0;
            for (int b = 0; b < N; b++) begin
                if (((c >> b) & 1) == 1) s += 1 << (N - 1 - b);
            end
            j = slot_tap[s];
            if (j >= 0) begin
                tap = (FOLD && c >= SLEN / 2) ? TAPS - 1 - j : j;
                xv  = int'(x[tap*XW +: XW]);
                if ((xv > ry_log[c]) != sg[tap]) ones++;
            end
        end
        return ones;
    endfunction

    // Issues one start and drives a fresh r_y each RUN cycle, logging the values.
    // Checks the handshake timing. With poke set, a start with different data is
    // pulsed mid-run.
    task automatic run_vec(input logic [XF-1:0] x, input logic [WF-1:0] w,
                           input logic [TAPS-1:0] sg, input bit poke);
        int early;
        bus.x_flat    = x;
        bus.w_flat    = w;
        bus.sign_mask = sg;
        bus.start     = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        check("busy_rise", int'(bus.busy), 1);
        early = 0;
        for (int j = 0; j < SLEN; j++) begin
            bus.r_y   = 4'($urandom_range(0, SLEN - 1));
            ry_log[j] = int'(bus.r_y);
            if (poke && j == 5) begin
                bus.start     = 1'b1;
                bus.x_flat    = ~x;
                bus.w_flat    = pk(0, 16, 0, 0);
                bus.sign_mask = ~sg;
            end
            if (poke && j == 6) bus.start = 1'b0;
            @(posedge clock); #1;
            if (bus.done) early++;
        end
        @(posedge clock); #1;
        if (bus.done) early++;
        @(posedge clock); #1;
        check("done_early", early, 0);
        check("done_pulse", int'(bus.done), 1);
        check("busy_fall", int'(bus.busy), 0);
        last_result = int'(bus.result);
    endtask

    initial begin
        vec_t vecs[8];
        logic [XF-1:0]   rx;
        logic [WF-1:0]   rw;
        logic [TAPS-1:0] rs;
        int exp, dones, busies;

        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{"w16_x16",      pk(16, 0, 0, 0),   pk(16, 0, 0, 0), 4'b0000, 16, 8};
        vecs[1] = '{"w16_x16_neg",  pk(16, 0, 0, 0),   pk(16, 0, 0, 0), 4'b0001, 0,  0};
        vecs[2] = '{"w8_8_alt",     pk(16, 0, 0, 0),   pk(8, 8, 0, 0),  4'b0000, 8,  4};
        vecs[3] = '{"w4_4_4_sum12", pk(16, 16, 16, 16), pk(4, 4, 4, 0), 4'b0000, 12, 8};
        vecs[4] = '{"w8_8_neg1",    pk(16, 16, 16, 16), pk(8, 8, 0, 0), 4'b0010, 8,  12};
        vecs[5] = '{"w12_12_over",  pk(0, 16, 0, 0),   pk(12, 12, 0, 0), 4'b0000, 4, 2};
        vecs[6] = '{"x0_neg_ones",  pk(0, 0, 0, 0),    pk(16, 0, 0, 0), 4'b0001, 16, 8};
        vecs[7] = '{"w0_all_zero",  pk(16, 16, 16, 16), pk(0, 0, 0, 0), 4'b1111, 0,  0};

        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.x_flat    = '0;
        bus.w_flat    = '0;
        bus.sign_mask = '0;
        bus.r_y       = '0;
        #12;
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_result", int'(bus.result), 0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Directed vectors; their outcome does not depend on r_y.
        for (int v = 0; v < 8; v++) begin
            run_vec(vecs[v].x, vecs[v].w, vecs[v].sg, 1'b0);
            check(vecs[v].name, last_result, FOLD ? vecs[v].exp_fold : vecs[v].exp_plain);
        end

        // done lasts exactly one cycle, and result holds while idle.
        @(posedge clock); #1;
        check("done_one_cycle", int'(bus.done), 0);
        repeat (3) @(posedge clock);
        #1;
        check("result_hold", int'(bus.result), FOLD ? vecs[7].exp_fold : vecs[7].exp_plain);

        // A start pulsed while busy is ignored, and the run keeps its shadowed data.
        run_vec(vecs[0].x, vecs[0].w, vecs[0].sg, 1'b1);
        check("start_ignored", last_result, FOLD ? 8 : 16);
        dones = 0;
        busies = 0;
        repeat (20) begin
            @(posedge clock); #1;
            if (bus.done) dones++;
            if (bus.busy) busies++;
        end
        check("start_not_queued", dones + busies, 0);

        // Reset at cycle 10 of a run aborts it without a done pulse.
        bus.x_flat    = vecs[0].x;
        bus.w_flat    = vecs[0].w;
        bus.sign_mask = vecs[0].sg;
        bus.start     = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (10) begin
            bus.r_y = 4'($urandom_range(0, SLEN - 1));
            @(posedge clock); #1;
        end
        reset_n = 1'b0;
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_result", int'(bus.result), 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        dones = 0;
        repeat (25) begin
            @(posedge clock); #1;
            if (bus.done) dones++;
        end
        check("abort_no_done", dones, 0);

        // Random runs checked against the slot-table model.
        for (int t = 0; t < 40; t++) begin
            rx = '0;
            rw = '0;
            for (int i = 0; i < TAPS; i++) begin
                rx[i*XW +: XW] = 5'($urandom_range(0, SLEN));
                rw[i*WW +: WW] = 5'($urandom_range(0, (t % 2 == 0) ? 6 : 10));
            end
            rs = 4'($urandom_range(0, 15));
            run_vec(rx, rw, rs, 1'b0);
            exp = model(rx, rw, rs);
            check("random_run", last_result, exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
